vblank_update_scheduler: RTL and testbench
==========================================

Name: vblank_update_scheduler

Overview:
- Sequences game-state updates so the sprite/score registers feeding vga_bitchange change only during vertical blanking. No tearing.
- Watches vCount from display_controller and detects vblank entry once per frame.
- Grants the update window to up to NUM_REQ requesters (player1, player2, collision/health) one at a time, using a req/grant/done handshake.
- Sits beside display_controller and vga_bitchange under vga_top.

Parameters:
- NUM_REQ, 3: number of requesters (1..8).
- VBLANK_START, 10'd480: first vCount line of vertical blank.
- TIMEOUT, 16'd2000: maximum clocks a single grant may be held.
- TO_W, 16: width of the timeout counter.

Ports:
- clk  input  1  system clock, same clock as display_controller.
- reset_n  input  1  asynchronous, active-low reset.
- vCount  input  10  current line from display_controller.
- req  input  NUM_REQ  level request, one bit per requester.
- done  input  NUM_REQ  one-cycle completion pulse from the granted requester.
- clr_err  input  1  synchronous clear of the sticky error flags.
- grant  output  NUM_REQ  one-hot update permission; all zero outside a grant.
- frame_tick  output  1  one-cycle pulse at vblank entry.
- busy  output  1  high in states SCAN and GRANT.
- frame_count  output  8  count of vblank entries, wraps 255 -> 0.
- overrun_err  output  1  sticky; a grant was still open when vblank ended.
- timeout_err  output  1  sticky; a grant hit TIMEOUT.

Behaviour:
- Reset (async, reset_n=0):
  - grant=0, frame_tick=0, busy=0, frame_count=0, overrun_err=0, timeout_err=0.
  - State=IDLE, pending mask=0, vblank_d=1 (prevents a false tick straight after reset).
  - Reset asserted mid-grant drops grant immediately.
- vblank = (vCount >= VBLANK_START); vblank_d is vblank registered each clk.
- vblank_rise = vblank & ~vblank_d.
- States:
  - IDLE:
    - On vblank_rise, go to SCAN.
    - Same edge: latch pending = req, pulse frame_tick high for the following cycle, increment frame_count.
    - req bits asserted after this latch wait for the next frame.
  - SCAN:
    - pending==0 -> WAIT.
    - Otherwise select the lowest-index set bit i and go to GRANT. grant[i] is high the cycle after SCAN.
    - SCAN lasts exactly one cycle.
  - GRANT:
    - Hold grant[i] and increment the timeout counter from 0.
    - done[i]=1: clear pending[i], grant=0 next cycle, go to SCAN.
    - Counter reaches TIMEOUT-1 without done: clear pending[i], set timeout_err, grant=0, go to SCAN.
    - vblank=0 (wrapped into active display): grant=0, set overrun_err, clear pending, go to IDLE.
    - done[i] and vblank falling in the same cycle: done wins, overrun_err not set, go to IDLE.
    - done on non-granted bits is ignored.
  - WAIT:
    - Idle until vblank=0, then go to IDLE.
    - Guarantees at most one schedule pass per frame.
- A vblank_rise seen in any state other than IDLE is ignored. This cannot occur with a legal vCount.
- Each latched requester is granted at most once per frame. Grants never overlap and at most one grant bit is ever high.
- Latency:
  - vblank_rise to first grant: 2 clks (frame_tick cycle = SCAN cycle, then GRANT).
  - done to next grant: 2 clks.
- clr_err clears both sticky flags. If an error event coincides with clr_err, the set wins.
- busy = (state==SCAN) | (state==GRANT).

Optional Feature:
- Macro: SCHED_ROUND_ROBIN_EN.
- Defined:
  - A rotating start pointer advances by 1 (mod NUM_REQ) at every vblank_rise.
  - SCAN selects the first set pending bit at or after the pointer, wrapping round.
  - Prevents a timing-out low-index requester from always consuming the window first.
- Undefined: fixed priority, lowest index first; no pointer register.

Test Plan:
- Reset, then vCount ramps 0..524 with req=3'b111 and each done pulsed 3 clks after its grant:
  - grant sequence 001, 010, 100.
  - First grant 2 clks after vCount hits 480.
  - frame_tick exactly once; frame_count=1; both error flags 0.
- req=3'b000 during a full frame: frame_tick pulses once, grant stays 0, busy high for exactly 1 clk (SCAN).
- req=3'b010 and done never pulsed, TIMEOUT=16:
  - grant=010 held 16 clks, then 0.
  - timeout_err=1; requester not re-granted in the same frame.
  - clr_err clears the flag.
- Hold done low and jump vCount from 524 to 0 mid-grant:
  - grant drops the next clk; overrun_err=1; state returns to IDLE.
  - Next frame's first grant occurs normally.
- Assert reset_n=0 asynchronously while grant=100: grant, busy and frame_count read 0 before the next clk edge.
- With SCHED_ROUND_ROBIN_EN, req=3'b111, two frames:
  - Frame 1 order is 010, 100, 001 (pointer advanced to 1 at the first vblank_rise after reset).
  - Frame 2 order is 100, 001, 010.

Source files
------------

// File: rtl/vblank_update_scheduler.sv
// Hands the vertical-blank update window to game-state requesters one at a time so that
// sprite/score registers only change off-screen. Define SCHED_ROUND_ROBIN_EN for rotating priority.
module vblank_update_scheduler #(
    parameter int unsigned     NUM_REQ      = 3,
    parameter logic [9:0]      VBLANK_START = 10'd480,
    parameter int unsigned     TO_W         = 16,
    parameter logic [TO_W-1:0] TIMEOUT      = TO_W'(2000)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [9:0]         vCount,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] done,
    input  logic               clr_err,
    output logic [NUM_REQ-1:0] grant,
    output logic               frame_tick,
    output logic               busy,
    output logic [7:0]         frame_count,
    output logic               overrun_err,
    output logic               timeout_err
);

    typedef enum logic [1:0] {StIdle, StScan, StGrant, StWait} state_e;

    localparam logic [TO_W-1:0] TO_LAST = TIMEOUT - TO_W'(1);

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] pending_q, pending_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [TO_W-1:0]    cnt_q, cnt_d;
    logic [7:0]         fcount_q, fcount_d;
    logic               tick_q, tick_d;
    logic               ovr_q, ovr_d;
    logic               tout_q, tout_d;
    logic               vblank_q;

    logic               vblank;
    logic               vblank_rise;
    logic [NUM_REQ-1:0] pick_oh;
    logic               pick_found;
    logic               done_hit;

    assign vblank      = (vCount >= VBLANK_START);
    assign vblank_rise = vblank & ~vblank_q;
    assign done_hit    = |(done & grant_q);

`ifdef SCHED_ROUND_ROBIN_EN
    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] ptr_q, ptr_d;

    // First pending bit at or after the pointer, otherwise wrap to the lowest set bit.
    always_comb begin
        pick_oh    = '0;
        pick_found = 1'b0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (!pick_found && pending_q[j] && (j >= 32'(ptr_q))) begin
                pick_oh[j] = 1'b1;
                pick_found = 1'b1;
            end
        end
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (!pick_found && pending_q[j]) begin
                pick_oh[j] = 1'b1;
                pick_found = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == StIdle && vblank_rise) begin
            ptr_d = (ptr_q == PTR_W'(NUM_REQ - 1)) ? '0 : ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        pick_oh    = '0;
        pick_found = 1'b0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (!pick_found && pending_q[j]) begin
                pick_oh[j] = 1'b1;
                pick_found = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        grant_d   = grant_q;
        cnt_d     = cnt_q;
        fcount_d  = fcount_q;
        tick_d    = 1'b0;
        // A coincident error event below overrides the clear.
        ovr_d     = clr_err ? 1'b0 : ovr_q;
        tout_d    = clr_err ? 1'b0 : tout_q;

        case (state_q)
            StIdle: begin
                if (vblank_rise) begin
                    state_d   = StScan;
                    pending_d = req;
                    tick_d    = 1'b1;
                    fcount_d  = fcount_q + 8'd1;
                end
            end
            StScan: begin
                if (!pick_found) begin
                    state_d = StWait;
                end else begin
                    state_d = StGrant;
                    grant_d = pick_oh;
                    cnt_d   = '0;
                end
            end
            StGrant: begin
                cnt_d = cnt_q + TO_W'(1);
                if (done_hit) begin
                    grant_d = '0;
                    if (vblank) begin
                        pending_d = pending_q & ~grant_q;
                        state_d   = StScan;
                    end else begin
                        pending_d = '0;
                        state_d   = StIdle;
                    end
                end else if (!vblank) begin
                    grant_d   = '0;
                    pending_d = '0;
                    ovr_d     = 1'b1;
                    state_d   = StIdle;
                end else if (cnt_q == TO_LAST) begin
                    grant_d   = '0;
                    pending_d = pending_q & ~grant_q;
                    tout_d    = 1'b1;
                    state_d   = StScan;
                end
            end
            StWait: begin
                if (!vblank) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // vblank_q resets high so a reset released inside blanking does not fake a frame start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            pending_q <= '0;
            grant_q   <= '0;
            cnt_q     <= '0;
            fcount_q  <= '0;
            tick_q    <= 1'b0;
            ovr_q     <= 1'b0;
            tout_q    <= 1'b0;
            vblank_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            grant_q   <= grant_d;
            cnt_q     <= cnt_d;
            fcount_q  <= fcount_d;
            tick_q    <= tick_d;
            ovr_q     <= ovr_d;
            tout_q    <= tout_d;
            vblank_q  <= vblank;
        end
    end

    assign grant       = grant_q;
    assign frame_tick  = tick_q;
    assign busy        = (state_q == StScan) || (state_q == StGrant);
    assign frame_count = fcount_q;
    assign overrun_err = ovr_q;
    assign timeout_err = tout_q;

endmodule

// File: tb/tb_vblank_update_scheduler.sv
// Directed bench for vblank_update_scheduler: expected grant order is queued per frame and
// compared as grants appear; frame-level counters are checked after each frame.
module tb_vblank_update_scheduler;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [9:0] vCount;
    logic [2:0] req;
    logic [2:0] done;
    logic       clr_err;
    logic [2:0] grant;
    logic       frame_tick;
    logic       busy;
    logic [7:0] frame_count;
    logic       overrun_err;
    logic       timeout_err;

    vblank_update_scheduler #(
        .NUM_REQ      (3),
        .VBLANK_START (10'd480),
        .TO_W         (16),
        .TIMEOUT      (16'd16)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .vCount      (vCount),
        .req         (req),
        .done        (done),
        .clr_err     (clr_err),
        .grant       (grant),
        .frame_tick  (frame_tick),
        .busy        (busy),
        .frame_count (frame_count),
        .overrun_err (overrun_err),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         t480 = 0;
    int         first_grant_cyc = 0;
    int         grants_seen = 0;
    int         tick_cnt = 0;
    int         busy_cnt = 0;
    int         ghi_cnt = 0;
    int         gcnt = 0;
    int         model_ptr = 0;
    bit         auto_done = 1'b0;
    logic [2:0] prev_grant = 3'b000;
    logic [2:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Requester model: pulse done for the granted bit on the third clock of its grant.
    always @(negedge clk) begin
        if (auto_done && grant != 3'b000) begin
            gcnt++;
            done = (gcnt == 3) ? grant : 3'b000;
        end else begin
            gcnt = 0;
            done = 3'b000;
        end
    end

    // Grant monitor: every new grant pops the scoreboard.
    always @(negedge clk) begin
        logic [2:0] e;
        if (reset_n) begin
            if (frame_tick) tick_cnt++;
            if (busy) busy_cnt++;
            if (grant != 3'b000) ghi_cnt++;
            if (grant != 3'b000 && grant != prev_grant) begin
                if (grants_seen == 0) first_grant_cyc = cyc;
                grants_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_grant", grant, 3'b000);
                end else begin
                    e = exp_q.pop_front();
                    check("grant_order", grant, e);
                end
            end
            prev_grant = grant;
        end else begin
            prev_grant = 3'b000;
        end
    end

    task automatic begin_frame(input logic [2:0] r, input bit ad);
        int         s;
        int         idx;
        logic [2:0] one;
        s         = 0;
        req       = r;
        auto_done = ad;
`ifdef SCHED_ROUND_ROBIN_EN
        model_ptr = (model_ptr + 1) % 3;
        s         = model_ptr;
`endif
        for (int k = 0; k < 3; k++) begin
            idx = (s + k) % 3;
            one = 3'b001;
            if (r[idx]) exp_q.push_back(one << idx);
        end
        tick_cnt    = 0;
        busy_cnt    = 0;
        ghi_cnt     = 0;
        grants_seen = 0;
    endtask

    task automatic ramp(input int from, input int to);
        for (int v = from; v <= to; v++) begin
            @(posedge clk);
            #1;
            vCount = 10'(v);
            if (v == 480) t480 = cyc;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        vCount  = 10'd0;
        req     = 3'b000;
        clr_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant", grant, 3'b000);
        check("rst_tick", frame_tick, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_fcount", frame_count, 8'd0);
        check("rst_ovr", overrun_err, 1'b0);
        check("rst_tout", timeout_err, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        // All three requesters, each finishing promptly.
        begin_frame(3'b111, 1'b1);
        ramp(0, 524);
        check("f1_grants", grants_seen, 3);
        check("f1_latency", first_grant_cyc - t480, 2);
        check("f1_ticks", tick_cnt, 1);
        check("f1_fcount", frame_count, 8'd1);
        check("f1_ovr", overrun_err, 1'b0);
        check("f1_tout", timeout_err, 1'b0);
        check("f1_drained", exp_q.size(), 0);

        // Nobody requesting: one SCAN cycle only.
        begin_frame(3'b000, 1'b1);
        ramp(0, 524);
        check("f2_ticks", tick_cnt, 1);
        check("f2_grants", grants_seen, 0);
        check("f2_ghi", ghi_cnt, 0);
        check("f2_busy", busy_cnt, 1);
        check("f2_fcount", frame_count, 8'd2);

        // Requester never completes: grant times out after 16 clocks.
        begin_frame(3'b010, 1'b0);
        ramp(0, 524);
        check("f3_grants", grants_seen, 1);
        check("f3_ghi", ghi_cnt, 16);
        check("f3_tout", timeout_err, 1'b1);
        check("f3_ovr", overrun_err, 1'b0);
        check("f3_fcount", frame_count, 8'd3);
        @(posedge clk);
        #1 clr_err = 1'b1;
        @(posedge clk);
        #1 clr_err = 1'b0;
        check("f3_clr", timeout_err, 1'b0);

        // Grant still open when vCount wraps back to active display.
        begin_frame(3'b100, 1'b0);
        ramp(0, 482);
        @(posedge clk);
        #1 vCount = 10'd524;
        @(posedge clk);
        #1 vCount = 10'd0;
        @(posedge clk);
        #1;
        check("ovr_grant_drop", grant, 3'b000);
        check("ovr_flag", overrun_err, 1'b1);
        check("ovr_idle", busy, 1'b0);
        check("ovr_grants", grants_seen, 1);

        // Next frame grants normally; reset lands while the grant is held.
        begin_frame(3'b100, 1'b0);
        ramp(1, 481);
        for (int i = 0; i < 20 && grant != 3'b100; i++) @(negedge clk);
        #1;
        check("f5_grant", grant, 3'b100);
        check("f5_latency", first_grant_cyc - t480, 2);
        check("f5_fcount", frame_count, 8'd5);
        check("f5_ovr_sticky", overrun_err, 1'b1);
        reset_n = 1'b0;
        #1;
        check("arst_grant", grant, 3'b000);
        check("arst_busy", busy, 1'b0);
        check("arst_fcount", frame_count, 8'd0);
        check("arst_ovr", overrun_err, 1'b0);
        exp_q.delete();
        model_ptr = 0;
        vCount    = 10'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Two consecutive full frames after reset.
        begin_frame(3'b111, 1'b1);
        ramp(0, 524);
        check("r1_grants", grants_seen, 3);
        check("r1_fcount", frame_count, 8'd1);
        check("r1_drained", exp_q.size(), 0);
        begin_frame(3'b111, 1'b1);
        ramp(0, 524);
        check("r2_grants", grants_seen, 3);
        check("r2_fcount", frame_count, 8'd2);
        check("r2_drained", exp_q.size(), 0);
        check("r2_errs", {overrun_err, timeout_err}, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
